// File: rtl/fc2_sequential_mac_84x10.sv
// FC2 layer of LeNet5 (84 -> 10): parallel input capture, one MAC per cycle against an
// external weight ROM, per-neuron saturated result strobes and a final argmax class index.
module fc2_sequential_mac_84x10 #(
    parameter int DATA_WIDTH   = 32,
    parameter int FRAC_BITS    = 16,
    parameter int N_IN         = 84,
    parameter int N_OUT        = 10,
    parameter int WM_ADDR_BITS = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [N_IN*DATA_WIDTH-1:0]   ifm_flat,
    output logic                         wm_rd_en,
    output logic [WM_ADDR_BITS-1:0]      wm_addr,
    input  logic [DATA_WIDTH-1:0]        wm_data,
    output logic [DATA_WIDTH-1:0]        fc2_data_out,
    output logic [3:0]                   fc2_out_index,
    output logic                         fc2_out_valid,
    output logic [3:0]                   class_out,
    output logic                         busy,
    output logic                         done
);

    localparam int ACC_WIDTH = 2*DATA_WIDTH-FRAC_BITS+8;
    localparam int K_W       = $clog2(N_IN+1);
    localparam logic [K_W-1:0] K_LAST = K_W'(N_IN);
    localparam logic [3:0]     N_LAST = 4'(N_OUT-1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT, S_DONE} state_t;
    state_t r_state, w_next;

    logic signed [DATA_WIDTH-1:0]   r_ifm [N_IN];
    logic [K_W-1:0]                 r_k;
    logic [K_W-1:0]                 r_k_p1;
    logic                           r_vld_p1;
    logic [3:0]                     r_n;
    logic [WM_ADDR_BITS-1:0]        r_addr;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [DATA_WIDTH-1:0]   r_best_val;
    logic [3:0]                     r_best_idx;
    logic                           w_start_ok;
    logic signed [DATA_WIDTH-1:0]   w_ifm_sel;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    w_term;
    logic signed [DATA_WIDTH-1:0]   w_sat;

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] a);
        if (a > ACC_MAX)
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (a < ACC_MIN)
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            return a[DATA_WIDTH-1:0];
    endfunction

    // done is still high in the first IDLE cycle, which keeps a start there from being taken while busy
    assign w_start_ok = start && !done;
    assign wm_addr    = r_addr;
    assign w_sat      = sat(r_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        wm_rd_en = 1'b0;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next = S_RUN;
            S_RUN: begin
                wm_rd_en = 1'b1;
                if (r_k == K_LAST) w_next = S_DRAIN;
            end
            S_DRAIN: w_next = S_OUT;
            S_OUT:   w_next = (r_n == N_LAST) ? S_DONE : S_RUN;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // p1: ROM word arrives alongside the registered k; the last k slot carries the bias
    always_comb begin
        w_ifm_sel = '0;
        if (r_k_p1 < K_LAST) w_ifm_sel = r_ifm[r_k_p1];
        w_prod = w_ifm_sel * $signed(wm_data);
        if (r_k_p1 == K_LAST) w_term = ACC_WIDTH'($signed(wm_data));
        else                  w_term = ACC_WIDTH'(w_prod >>> FRAC_BITS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) r_ifm[i] <= '0;
            r_k           <= '0;
            r_k_p1        <= '0;
            r_vld_p1      <= 1'b0;
            r_n           <= '0;
            r_addr        <= '0;
            r_acc         <= '0;
            r_best_val    <= '0;
            r_best_idx    <= '0;
            fc2_data_out  <= '0;
            fc2_out_index <= '0;
            fc2_out_valid <= 1'b0;
            class_out     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            fc2_out_valid <= 1'b0;
            done          <= 1'b0;
            r_vld_p1      <= 1'b0;
            if (r_vld_p1) r_acc <= r_acc + w_term;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        for (int i = 0; i < N_IN; i++)
                            r_ifm[i] <= $signed(ifm_flat[i*DATA_WIDTH +: DATA_WIDTH]);
                        r_k       <= '0;
                        r_n       <= '0;
                        r_addr    <= '0;
                        r_acc     <= '0;
                        busy      <= 1'b1;
                        class_out <= '0;
                    end else if (done) begin
                        busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_k_p1   <= r_k;
                    r_vld_p1 <= 1'b1;
                    r_k      <= r_k + 1'b1;
                    if (r_k != K_LAST) r_addr <= r_addr + 1'b1;
                end
                S_OUT: begin
                    fc2_out_valid <= 1'b1;
                    fc2_data_out  <= w_sat;
                    fc2_out_index <= r_n;
                    if (r_n == '0 || w_sat > r_best_val) begin
                        r_best_val <= w_sat;
                        r_best_idx <= r_n;
                    end
                    r_acc <= '0;
                    r_k   <= '0;
                    if (r_n != N_LAST) begin
                        r_n    <= r_n + 1'b1;
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_DONE: begin
                    done      <= 1'b1;
                    class_out <= r_best_idx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc2_sequential_mac_84x10.sv
// Randomized bench for the FC2 sequential MAC: ROM model plus a dot-product reference
// computed with plain 64-bit arithmetic, checked per scenario task.
module tb_fc2_sequential_mac_84x10;

    localparam int DW = 32;
    localparam int NI = 84;
    localparam int NO = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [NI*DW-1:0] ifm_flat = '0;
    logic            wm_rd_en;
    logic [9:0]      wm_addr;
    logic [31:0]     wm_data = '0;
    logic [31:0]     fc2_data_out;
    logic [3:0]      fc2_out_index;
    logic            fc2_out_valid;
    logic [3:0]      class_out;
    logic            busy;
    logic            done;

    fc2_sequential_mac_84x10 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ifm_flat(ifm_flat),
        .wm_rd_en(wm_rd_en), .wm_addr(wm_addr), .wm_data(wm_data),
        .fc2_data_out(fc2_data_out), .fc2_out_index(fc2_out_index),
        .fc2_out_valid(fc2_out_valid), .class_out(class_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [1024];
    always @(posedge clk) if (wm_rd_en) wm_data <= rom[wm_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    int signed ifm_m [NI];
    logic [31:0] exp_d [NO];
    int exp_class;
    int str_t [16];
    logic [31:0] str_d [16];
    logic [3:0] str_i [16];
    int n_str, done_cnt, done_t;
    logic [3:0] done_class;
    logic busy_done, busy_after;

    task automatic load_ifm();
        for (int k = 0; k < NI; k++) ifm_flat[k*DW +: DW] = ifm_m[k];
    endtask

    // Reference: y[n] = sat(bias[n] + sum_k (x[k]*w[n][k]) >>> 16), argmax with lowest index on ties
    task automatic model();
        longint acc, best;
        best = 0;
        for (int n = 0; n < NO; n++) begin
            acc = longint'($signed(rom[n*85+84]));
            for (int k = 0; k < NI; k++)
                acc += (longint'(ifm_m[k]) * longint'($signed(rom[n*85+k]))) >>> 16;
            if (acc > 64'sd2147483647) acc = 64'sd2147483647;
            else if (acc < -64'sd2147483648) acc = -64'sd2147483648;
            exp_d[n] = acc[31:0];
            if (n == 0 || acc > best) begin
                best = acc;
                exp_class = n;
            end
        end
    endtask

    task automatic run_job(input bit extra);
        n_str = 0; done_cnt = 0; done_t = -1; done_class = '0;
        busy_done = 1'b0; busy_after = 1'b1;
        for (int i = 0; i < 16; i++) begin
            str_t[i] = -1; str_d[i] = 'x; str_i[i] = 'x;
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 880; c++) begin
            start = extra && (c == 100 || c == 500);
            if (extra && c == 50)
                for (int k = 0; k < NI; k++) ifm_flat[k*DW +: DW] = $urandom;
            @(negedge clk);
            if (fc2_out_valid) begin
                if (n_str < 16) begin
                    str_t[n_str] = c; str_d[n_str] = fc2_data_out; str_i[n_str] = fc2_out_index;
                end
                n_str++;
            end
            if (done) begin
                done_cnt++; done_t = c; done_class = class_out; busy_done = busy;
            end
            if (c == 872) busy_after = busy;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_chk++;
        if ({fc2_data_out, fc2_out_index, fc2_out_valid, class_out, busy, done, wm_rd_en, wm_addr} !== '0)
            $display("FAIL reset_outputs got %h exp 0", {fc2_data_out, fc2_out_index, fc2_out_valid,
                     class_out, busy, done, wm_rd_en, wm_addr});
        else n_pass++;
    endtask

    task automatic test_bias_ramp(input bit extra);
        for (int k = 0; k < NI; k++) ifm_m[k] = int'($urandom);
        load_ifm();
        for (int n = 0; n < NO; n++) begin
            for (int k = 0; k < NI; k++) rom[n*85+k] = '0;
            rom[n*85+84] = 32'(n) << 16;
        end
        model();
        run_job(extra);
        n_chk++;
        if (n_str !== NO) $display("FAIL ramp_strobe_count got %0d exp %0d", n_str, NO); else n_pass++;
        for (int n = 0; n < NO; n++) begin
            n_chk++;
            if (str_t[n] !== 87*(n+1) || str_d[n] !== exp_d[n] || str_i[n] !== 4'(n))
                $display("FAIL ramp_neuron%0d got t=%0d d=%h i=%0d exp t=%0d d=%h i=%0d",
                         n, str_t[n], str_d[n], str_i[n], 87*(n+1), exp_d[n], n);
            else n_pass++;
        end
        n_chk++;
        if (done_cnt !== 1 || done_t !== 871)
            $display("FAIL ramp_done got cnt=%0d t=%0d exp cnt=1 t=871", done_cnt, done_t);
        else n_pass++;
        n_chk++;
        if (done_class !== 4'(exp_class))
            $display("FAIL ramp_class got %0d exp %0d", done_class, exp_class);
        else n_pass++;
        n_chk++;
        if (busy_done !== 1'b1 || busy_after !== 1'b0 || class_out !== 4'(exp_class))
            $display("FAIL ramp_busy_hold got busy_done=%b busy_after=%b class=%0d exp 1 0 %0d",
                     busy_done, busy_after, class_out, exp_class);
        else n_pass++;
    endtask

    task automatic test_single_neuron();
        for (int k = 0; k < NI; k++) ifm_m[k] = 32'h0001_0000;
        load_ifm();
        for (int i = 0; i < NO*85; i++) rom[i] = '0;
        for (int k = 0; k < NI; k++) rom[3*85+k] = 32'h0000_8000;
        model();
        run_job(1'b0);
        n_chk++;
        if (fc2_data_out !== exp_d[NO-1] || str_d[3] !== exp_d[3] || str_d[3] !== 32'h002A_0000)
            $display("FAIL single_neuron3 got %h exp %h", str_d[3], exp_d[3]);
        else n_pass++;
        n_chk++;
        if (done_class !== 4'(exp_class) || n_str !== NO)
            $display("FAIL single_class got %0d/%0d exp %0d/%0d", done_class, n_str, exp_class, NO);
        else n_pass++;
    endtask

    task automatic test_saturation(input logic [31:0] wv);
        for (int k = 0; k < NI; k++) ifm_m[k] = 32'h7FFF_FFFF;
        load_ifm();
        for (int i = 0; i < NO*85; i++) rom[i] = wv;
        model();
        run_job(1'b0);
        for (int n = 0; n < NO; n++) begin
            n_chk++;
            if (str_d[n] !== exp_d[n])
                $display("FAIL sat_%h_n%0d got %h exp %h", wv, n, str_d[n], exp_d[n]);
            else n_pass++;
        end
        n_chk++;
        if (done_class !== 4'(exp_class))
            $display("FAIL sat_class got %0d exp %0d", done_class, exp_class);
        else n_pass++;
    endtask

    task automatic test_tie_break();
        for (int k = 0; k < NI; k++) ifm_m[k] = int'($urandom);
        load_ifm();
        for (int n = 0; n < NO; n++) begin
            for (int k = 0; k < NI; k++) rom[n*85+k] = '0;
            rom[n*85+84] = 32'h0001_0000;
        end
        model();
        run_job(1'b0);
        n_chk++;
        if (done_class !== 4'(exp_class) || done_class !== 4'd0)
            $display("FAIL tie_class got %0d exp %0d", done_class, exp_class);
        else n_pass++;
    endtask

    task automatic test_random(input bit wide);
        for (int k = 0; k < NI; k++)
            ifm_m[k] = wide ? int'($urandom) : int'($urandom_range(0, 32'hFFFFF)) - (1 << 19);
        load_ifm();
        for (int n = 0; n < NO; n++) begin
            for (int k = 0; k < NI; k++)
                rom[n*85+k] = wide ? $urandom : 32'($urandom_range(0, 32'h3FFFF) - (1 << 17));
            rom[n*85+84] = wide ? $urandom : 32'($urandom_range(0, 32'h7FFFFF) - (1 << 22));
        end
        model();
        run_job(1'b0);
        for (int n = 0; n < NO; n++) begin
            n_chk++;
            if (str_d[n] !== exp_d[n] || str_i[n] !== 4'(n))
                $display("FAIL random%0d_n%0d got %h/%0d exp %h/%0d", wide, n, str_d[n], str_i[n], exp_d[n], n);
            else n_pass++;
        end
        n_chk++;
        if (done_class !== 4'(exp_class))
            $display("FAIL random%0d_class got %0d exp %0d", wide, done_class, exp_class);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int strobes;
        strobes = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({fc2_data_out, fc2_out_index, fc2_out_valid, class_out, busy, done, wm_rd_en, wm_addr} !== '0)
            $display("FAIL midreset_outputs got %h exp 0", {fc2_data_out, fc2_out_index, fc2_out_valid,
                     class_out, busy, done, wm_rd_en, wm_addr});
        else n_pass++;
        repeat (2) begin
            @(negedge clk);
            if (fc2_out_valid || done) strobes++;
        end
        rst_n = 1'b1;
        repeat (700) begin
            @(negedge clk);
            if (fc2_out_valid || done || busy) strobes++;
        end
        n_chk++;
        if (strobes !== 0) $display("FAIL midreset_quiet got %0d exp 0", strobes); else n_pass++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_bias_ramp(1'b0);
        test_single_neuron();
        test_saturation(32'h7FFF_FFFF);
        test_saturation(32'h8000_0001);
        test_tie_break();
        test_random(1'b0);
        test_random(1'b1);
        test_bias_ramp(1'b1);
        test_reset_mid_run();
        test_bias_ramp(1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
